// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: set-associative write-back/write-allocate cache controller with flush.
// Optional CACHE_STATS_EN adds hit/miss/write-back counters.
module assoc_cache_ctrl #(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              flush_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - OW - IW;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL, RESP, FLUSH_SCAN, FLUSH_WB} state_e;

  state_e state_q, state_d;
  logic [TW-1:0]     tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WW-1:0]     rr_q    [SETS];
  logic              we_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [WW-1:0]     way_q, fway_q;
  logic [OW-1:0]     cnt_q;
  logic [IW-1:0]     fset_q;

  logic [OW-1:0] off;
  logic [IW-1:0] idx, bs;
  logic [TW-1:0] tag;
  logic [WW-1:0] hit_way, vict, bw;
  logic          hit, beat, last, last_ent, fdirty, fadv;

  assign off      = addr_q[OW-1:0];
  assign idx      = addr_q[OW+IW-1:OW];
  assign tag      = addr_q[ADDR_W-1:OW+IW];
  assign last     = &cnt_q;
  assign last_ent = fset_q == IW'(SETS-1) && fway_q == WW'(WAYS-1);
  assign fdirty   = dirty_q[fset_q][fway_q];
  // Write-back beats come from the request's victim or from the flush scan pointer.
  assign bs       = state_q == FLUSH_WB ? fset_q : idx;
  assign bw       = state_q == FLUSH_WB ? fway_q : way_q;
  assign beat     = mem_req_valid && mem_req_ready;
  assign fadv     = (state_q == FLUSH_SCAN && !fdirty) || (state_q == FLUSH_WB && beat && last);

  // Descending scan so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vict    = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) vict = WW'(w);
    end
  end

  always_comb begin
    req_ready     = rst_n && state_q == IDLE && !flush;
    resp_valid    = state_q == RESP;
    resp_rdata    = rdata_q;
    resp_hit      = hit_q;
    mem_req_valid = state_q == WB || state_q == FILL_REQ || state_q == FLUSH_WB;
    mem_req_we    = state_q == WB || state_q == FLUSH_WB;
    mem_req_addr  = state_q == FILL_REQ ? {tag, idx, OW'(0)} : {tag_q[bs][bw], bs, cnt_q};
    mem_wdata     = data_q[bs][bw][cnt_q];
    flush_done    = (state_q == FLUSH_SCAN && !fdirty && last_ent) ||
                    (state_q == FLUSH_WB && beat && last && last_ent);
    state_d       = state_q;
    unique case (state_q)
      IDLE:       state_d = flush ? FLUSH_SCAN : req_valid ? LOOKUP : IDLE;
      LOOKUP:     state_d = hit ? RESP : (valid_q[idx][vict] && dirty_q[idx][vict]) ? WB : FILL_REQ;
      WB:         state_d = beat && last ? FILL_REQ : WB;
      FILL_REQ:   state_d = mem_req_ready ? FILL : FILL_REQ;
      FILL:       state_d = mem_rvalid && last ? RESP : FILL;
      RESP:       state_d = resp_ready ? IDLE : RESP;
      FLUSH_SCAN: state_d = fdirty ? FLUSH_WB : last_ent ? IDLE : FLUSH_SCAN;
      FLUSH_WB:   state_d = beat && last ? (last_ent ? IDLE : FLUSH_SCAN) : FLUSH_WB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fset_q  <= '0;
      fway_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == LOOKUP && hit && we_q) dirty_q[idx][hit_way] <= 1'b1;
      if (state_q == LOOKUP && !hit && valid_q[idx][vict])
        rr_q[idx] <= rr_q[idx] == WW'(WAYS-1) ? '0 : rr_q[idx] + 1'b1;
      if ((mem_req_we && beat) || (state_q == FILL && mem_rvalid)) cnt_q <= cnt_q + 1'b1;
      if (state_q == FILL && mem_rvalid && last) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= we_q;
      end
      if (state_q == FLUSH_WB && beat && last) dirty_q[fset_q][fway_q] <= 1'b0;
      if (fadv) begin
        fway_q <= fway_q == WW'(WAYS-1) ? '0 : fway_q + 1'b1;
        if (fway_q == WW'(WAYS-1)) fset_q <= fset_q + 1'b1;
      end
`ifdef CACHE_STATS_EN
      if (state_q == LOOKUP && hit) hit_count <= hit_count + 1;
      if (state_q == LOOKUP && !hit) miss_count <= miss_count + 1;
      if (mem_req_we && beat && last) wb_count <= wb_count + 1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid && req_ready) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
    if (state_q == LOOKUP) begin
      hit_q <= hit;
      way_q <= hit ? hit_way : vict;
      if (hit) rdata_q <= we_q ? wdata_q : data_q[idx][hit_way][off];
      if (hit && we_q) data_q[idx][hit_way][off] <= wdata_q;
    end
    if (state_q == FILL && mem_rvalid) begin
      data_q[idx][way_q][cnt_q] <= (we_q && cnt_q == off) ? wdata_q : mem_rdata;
      if (cnt_q == off) rdata_q <= we_q ? wdata_q : mem_rdata;
      if (last) tag_q[idx][way_q] <= tag;
    end
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: scoreboard bench for assoc_cache_ctrl with a behavioural memory.
module tb_assoc_cache_ctrl;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_hit;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_rvalid, flush, flush_done;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_req_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  assoc_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_hit(resp_hit), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .flush_done(flush_done)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic h;} exp_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} beat_t;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  exp_t        sb[$];
  beat_t       wb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] fill_base;
  int fill_left = 0, fill_idx = 0, rst_beat = -1, flush_pulses = 0, resp_hold = 0;
  int checks = 0, passes = 0;
  bit stall_en = 0, beat_held = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] gold_val(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // Memory slave: grants commands, returns fill beats on later cycles, logs every beat.
  initial begin
    beat_t b;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fill_left = 0;
        mem_rvalid = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (fill_left > 0 && (!stall_en || $urandom_range(3) != 0)) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_val(fill_base + 32'(fill_idx));
          fill_idx++;
          fill_left--;
        end else begin
          mem_rvalid = 1'b0;
        end
        mem_req_ready = stall_en ? ($urandom_range(2) != 0) : 1'b1;
        if (mem_req_valid && mem_req_we && wb_q.size() == rst_beat) begin
          mem_req_ready = 1'b0;
          beat_held = 1'b1;
        end
        #1;
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_we) begin
            b.a = mem_req_addr;
            b.d = mem_wdata;
            wb_q.push_back(b);
            mem[mem_req_addr] = mem_wdata;
          end else begin
            rd_q.push_back(mem_req_addr);
            fill_base = mem_req_addr;
            fill_idx = 0;
            fill_left = LW;
          end
        end
        if (flush_done) flush_pulses++;
      end
    end
  end

  // Response side: optional backpressure, stability while stalled, scoreboard pop on handshake.
  initial begin
    exp_t e;
    int held = 0;
    bit seen = 0;
    logic [31:0] hd;
    logic hh;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (seen) begin
          checks++;
          if (resp_rdata !== hd || resp_hit !== hh || req_ready !== 1'b0)
            $display("FAIL resp_stable: rdata=%h hit=%b req_ready=%b, required rdata=%h hit=%b req_ready=0",
                     resp_rdata, resp_hit, req_ready, hd, hh);
          else passes++;
        end else begin
          hd = resp_rdata;
          hh = resp_hit;
        end
        seen = 1'b1;
        resp_ready = held >= resp_hold;
        held++;
        if (resp_ready) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL resp_unexpected: got rdata=%h, required no response", resp_rdata);
          end else begin
            e = sb.pop_front();
            if (resp_rdata !== e.d) $display("FAIL resp_rdata: got %h, required %h", resp_rdata, e.d);
            else passes++;
            checks++;
            if (resp_hit !== e.h) $display("FAIL resp_hit: got %b, required %b", resp_hit, e.h);
            else passes++;
          end
          held = 0;
          seen = 1'b0;
        end
      end else begin
        resp_ready = 1'b0;
        held = 0;
        seen = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic eh, input int elat, input string nm);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      checks++;
      $display("FAIL %s_accept: req_ready=0 after %0d cycles, required 1", nm, n);
      req_valid = 1'b0;
      return;
    end
    e.d = we ? d : gold_val(a);
    e.h = eh;
    if (we) gold[a] = d;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 500) begin @(negedge clk); n++; end
    if (elat >= 0 || n >= 500) begin
      checks++;
      if (n != elat) $display("FAIL %s_latency: got %0d cycles, required %0d", nm, n, elat);
      else passes++;
    end
    while (sb.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL %s_resp: %0d responses missing, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b, required 0", req_ready); else passes++;
    if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b, required 0", resp_valid); else passes++;
    if (mem_req_valid !== 1'b0) $display("FAIL rst_mem_req_valid: got %b, required 0", mem_req_valid); else passes++;
    if (flush_done !== 1'b0) $display("FAIL rst_flush_done: got %b, required 0", flush_done); else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b, required 1", req_ready); else passes++;
  endtask

  task automatic test_read_miss;
    rd_q.delete();
    do_req(1'b0, 32'h40, '0, 1'b0, -1, "miss40");
    checks += 2;
    if (rd_q.size() != 1) $display("FAIL miss40_reads: got %0d reads, required 1", rd_q.size()); else passes++;
    if (rd_q.size() == 0 || rd_q[0] !== 32'h40)
      $display("FAIL miss40_base: got %h, required 00000040", rd_q.size() ? rd_q[0] : 32'hx);
    else passes++;
    do_req(1'b0, 32'h41, '0, 1'b1, 2, "hit41");
  endtask

  task automatic test_write_evict;
    stall_en = 1'b1;
    do_req(1'b1, 32'h42, 32'hDEAD_BEEF, 1'b1, 2, "wr42");
    wb_q.delete();
    for (int k = 1; k <= 4; k++) do_req(1'b0, 32'h40 + 32'(k * 256), '0, 1'b0, -1, "evict");
    checks++;
    if (wb_q.size() != LW) $display("FAIL evict_beats: got %0d, required %0d", wb_q.size(), LW); else passes++;
    for (int i = 0; i < LW && i < wb_q.size(); i++) begin
      checks += 2;
      if (wb_q[i].a !== 32'h40 + 32'(i)) $display("FAIL evict_addr%0d: got %h, required %h", i, wb_q[i].a, 32'h40 + 32'(i));
      else passes++;
      if (wb_q[i].d !== gold_val(32'h40 + 32'(i))) $display("FAIL evict_data%0d: got %h, required %h", i, wb_q[i].d, gold_val(32'h40 + 32'(i)));
      else passes++;
    end
  endtask

  task automatic test_resp_stall;
    resp_hold = 5;
    do_req(1'b0, 32'h442, '0, 1'b1, 2, "stall");
    resp_hold = 0;
  endtask

  task automatic test_flush;
    logic [31:0] ea;
    int n;
    do_req(1'b1, 32'h2000, 32'hA5A5_0000, 1'b0, -1, "fl_wr0");
    do_req(1'b1, 32'h2104, 32'h5A5A_0001, 1'b0, -1, "fl_wr1");
    wb_q.delete();
    flush_pulses = 0;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2001;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL flush_prio: req_ready=%b, required 0", req_ready); else passes++;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n = 0;
    while (flush_pulses == 0 && n < 3000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks += 2;
    if (flush_pulses != 1) $display("FAIL flush_done_pulses: got %0d, required 1", flush_pulses); else passes++;
    if (wb_q.size() != 2 * LW) $display("FAIL flush_beats: got %0d, required %0d", wb_q.size(), 2 * LW); else passes++;
    for (int i = 0; i < 2 * LW && i < wb_q.size(); i++) begin
      ea = (i < LW ? 32'h2000 : 32'h2104) + 32'(i % LW);
      checks += 2;
      if (wb_q[i].a !== ea) $display("FAIL flush_addr%0d: got %h, required %h", i, wb_q[i].a, ea); else passes++;
      if (wb_q[i].d !== gold_val(ea)) $display("FAIL flush_data%0d: got %h, required %h", i, wb_q[i].d, gold_val(ea));
      else passes++;
    end
    do_req(1'b0, 32'h2001, '0, 1'b1, 2, "post_flush");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'h1014 + 32'(i * 256), 32'hB000_0000 + 32'(i), 1'b0, -1, "b2b_wmiss");
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'h1015 + 32'(i * 256), '0, 1'b1, 2, "b2b_rhit");
    do_req(1'b1, 32'h1016, 32'h1234_5678, 1'b1, 2, "b2b_whit");
    do_req(1'b0, 32'h1016, '0, 1'b1, 2, "b2b_rback");
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid_wb;
    int n, act;
    wb_q.delete();
    beat_held = 1'b0;
    rst_beat = 2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1414;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!beat_held && n < 200) begin @(negedge clk); #2; n++; end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (!beat_held) $display("FAIL rst_wb_reach: beat 2 never presented, required presented");
    else passes++;
    if (mem_req_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b, required 0", mem_req_valid); else passes++;
    if (wb_q.size() != 2) $display("FAIL rst_wb_beats: got %0d, required 2", wb_q.size()); else passes++;
    repeat (2) @(negedge clk);
    rst_beat = -1;
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin @(negedge clk); if (mem_req_valid || resp_valid) act++; end
    checks++;
    if (act != 0) $display("FAIL rst_quiet: got %0d active cycles, required 0", act); else passes++;
    do_req(1'b0, 32'h2001, '0, 1'b0, -1, "rst_miss0");
    do_req(1'b0, 32'h1015, '0, 1'b0, -1, "rst_miss1");
    do_req(1'b0, 32'h42, '0, 1'b0, -1, "rst_miss2");
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h3000, '0, 1'b0, -1, "st_miss");
    do_req(1'b0, 32'h3001, '0, 1'b1, 2, "st_hit0");
    do_req(1'b0, 32'h3002, '0, 1'b1, 2, "st_hit1");
    checks += 3;
    if (hit_count !== 32'd2) $display("FAIL hit_count: got %0d, required 2", hit_count); else passes++;
    if (miss_count !== 32'd1) $display("FAIL miss_count: got %0d, required 1", miss_count); else passes++;
    if (wb_count !== 32'd0) $display("FAIL wb_count: got %0d, required 0", wb_count); else passes++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_read_miss;
    test_write_evict;
    test_resp_stall;
    test_flush;
    test_back_to_back;
    test_reset_mid_wb;
`ifdef CACHE_STATS_EN
    test_stats;
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
